// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared RISC-V definitions for the multiply/divide unit
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
        MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_oper_t;

    typedef enum logic [1:0] {
        S_IDLE, S_MUL, S_DIV, S_DONE
    } md_state_t;

    function automatic logic md_is_div(input md_oper_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_is_rem(input md_oper_t op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    function automatic logic md_signed1(input md_oper_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_signed2(input md_oper_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension unit; divider compiled in with MULDIV_DIV_EN
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  md_oper_t        op_i,
    input  logic [XLEN-1:0] oper1_i,
    input  logic [XLEN-1:0] oper2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

    md_state_t       state_q, state_d;
    md_oper_t        op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d, sh_q, sh_d, b_q, b_d, cnt_q, cnt_d, res_q, res_d;
    logic            neg_q, neg_d, ill_q, ill_d;

    // operand signs and magnitudes at the accept edge
    logic            s1, s2;
    logic [XLEN-1:0] mag1, mag2;
    assign s1   = md_signed1(op_i) & oper1_i[XLEN-1];
    assign s2   = md_signed2(op_i) & oper2_i[XLEN-1];
    assign mag1 = s1 ? -oper1_i : oper1_i;
    assign mag2 = s2 ? -oper2_i : oper2_i;

    // shift-add step: {acc, sh} holds the partial product, multiplier shifting out of sh
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_acc_n, mul_sh_n, mul_res;
    logic [2*XLEN-1:0] prod, prod_s;
    assign mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    assign mul_acc_n = mul_sum[XLEN:1];
    assign mul_sh_n  = {mul_sum[0], sh_q[XLEN-1:1]};
    assign prod      = {mul_acc_n, mul_sh_n};
    assign prod_s    = neg_q ? -prod : prod;
    assign mul_res   = (op_q == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // restoring step: acc is the partial remainder, quotient bits shift into sh
    logic [XLEN:0]   div_t, div_diff;
    logic            div_ge, ovf;
    logic [XLEN-1:0] div_acc_n, div_sh_n, div_mag, div_res;
    assign div_t     = {acc_q, sh_q[XLEN-1]};
    assign div_diff  = div_t - {1'b0, b_q};
    assign div_ge    = ~div_diff[XLEN];
    assign div_acc_n = div_ge ? div_diff[XLEN-1:0] : div_t[XLEN-1:0];
    assign div_sh_n  = {sh_q[XLEN-2:0], div_ge};
    assign div_mag   = md_is_rem(op_q) ? div_acc_n : div_sh_n;
    assign div_res   = neg_q ? -div_mag : div_mag;
    assign ovf       = md_signed2(op_i) && oper1_i == MIN_NEG && oper2_i == '1;
`endif

    assign busy_o    = state_q != S_IDLE;
    assign done_o    = state_q == S_DONE;
    assign illegal_o = done_o & ill_q;
    assign result_o  = res_q;

    // next-state and datapath: one shared accumulator/shift register/counter for both ops
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        res_d   = res_q;
        ill_d   = ill_q;
        unique case (state_q)
            S_IDLE: if (start_i) begin
                op_d  = op_i;
                acc_d = '0;
                sh_d  = mag1;
                b_d   = mag2;
                cnt_d = '0;
                neg_d = md_is_rem(op_i) ? s1 : s1 ^ s2;
                ill_d = 1'b0;
                if (md_is_div(op_i)) begin
`ifdef MULDIV_DIV_EN
                    if (oper2_i == '0) begin
                        state_d = S_DONE;
                        res_d   = md_is_rem(op_i) ? oper1_i : '1;
                    end else if (ovf) begin
                        state_d = S_DONE;
                        res_d   = md_is_rem(op_i) ? '0 : oper1_i;
                    end else begin
                        state_d = S_DIV;
                    end
`else
                    state_d = S_DONE;
                    res_d   = '0;
                    ill_d   = 1'b1;
`endif
                end else begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = mul_acc_n;
                sh_d  = mul_sh_n;
                cnt_d = cnt_q + XLEN'(1);
                if (cnt_q == XLEN'(XLEN-1)) begin
                    state_d = S_DONE;
                    res_d   = mul_res;
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                acc_d = div_acc_n;
                sh_d  = div_sh_n;
                cnt_d = cnt_q + XLEN'(1);
                if (cnt_q == XLEN'(XLEN-1)) begin
                    state_d = S_DONE;
                    res_d   = div_res;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            res_d   = res_q;
            ill_d   = ill_q;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= MD_MUL;
            acc_q   <= '0;
            sh_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
        end
    end

endmodule
